// File: rtl/risky_soc_pkg.sv
// risky_soc_pkg: shared constants and types for the memory responder slice.
//   IO_SEL_BIT       address bit selecting the MMIO page over RAM
//   io_reg_e         MMIO register index taken from mem_addr[3:2]
//   STATUS_*_BIT     bit positions inside the UART_STATUS word
//   tx_state_e       UART serializer state encoding
package risky_soc_pkg;

    localparam int IO_SEL_BIT = 22;

    typedef enum logic [1:0] {
        IO_LEDS        = 2'd0,
        IO_UART_DATA   = 2'd1,
        IO_UART_STATUS = 2'd2,
        IO_RESERVED    = 2'd3
    } io_reg_e;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_FULL_BIT = 1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: processor memory bus.
//   mem_addr   byte address            (master -> slave)
//   mem_rstrb  read strobe             (master -> slave)
//   mem_wmask  byte-lane write enables (master -> slave)
//   mem_wdata  lane-replicated data    (master -> slave)
//   mem_rdata  registered read data    (slave -> master)
interface mem_responder_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_rstrb;
    logic [3:0]      mem_wmask;
    logic [XLEN-1:0] mem_wdata;

    modport master (output mem_addr, mem_rstrb, mem_wmask, mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, mem_rstrb, mem_wmask, mem_wdata, output mem_rdata);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 transmitter, LSB first.
//   clk, reset  clock and synchronous active-high reset
//   tx_data     byte presented by the FIFO head
//   tx_valid    FIFO non-empty
//   tx_ready    serializer takes tx_data at this edge (pop)
//   uart_tx     registered serial line, idle high
//   busy        a frame is in flight
module uart_tx_serializer
    import risky_soc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       busy
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             cnt_end;

    assign cnt_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // The line level is computed from the next state and registered so
    // uart_tx comes straight from a flop.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        tx_ready = 1'b0;
        case (state_q)
            TX_IDLE: begin
                tx_ready = 1'b1;
                cnt_d    = '0;
                if (tx_valid) begin
                    state_d = TX_START;
                    shift_d = tx_data;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                    tx_d    = shift_q[0];
                end
            end
            TX_DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                cnt_d    = cnt_q + 1'b1;
                // Popping on the last stop cycle chains frames with no idle gap.
                tx_ready = cnt_end;
                if (cnt_end) begin
                    cnt_d = '0;
                    if (tx_valid) begin
                        state_d = TX_START;
                        shift_d = tx_data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign uart_tx = tx_q;
    assign busy    = (state_q != TX_IDLE);

endmodule

// File: rtl/mem_responder.sv
// mem_responder: target side of the processor memory bus.
//   Byte-maskable word RAM plus an MMIO page (mem_addr[22]=1) holding
//   LEDS (0x0), UART_DATA (0x4), UART_STATUS (0x8); 0xC reserved.
//   Reads complete in one cycle; mem_rdata only changes on a strobed edge.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   bus         mem_responder_if.slave (addr/rstrb/wmask/wdata in, rdata out)
//   leds        LED register
//   uart_tx     serial output, idle high
// Build option: MEM_RESPONDER_UART_EN adds the UART FIFO and serializer;
//   without it uart_tx is tied high, UART_DATA writes are ignored and
//   UART_STATUS reads 0.
module mem_responder
    import risky_soc_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_WORDS   = 2048,
    parameter int NUM_LEDS    = 5,
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_responder_if.slave      bus,
    output logic [NUM_LEDS-1:0] leds,
    output logic                uart_tx
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    logic             io_sel;
    io_reg_e          io_reg;
    logic [IDX_W-1:0] ram_idx;
    logic             wr_any;
    logic [XLEN-1:0]  status_word;
    logic [XLEN-1:0]  rdata_d;

    // Address bits above the RAM index are ignored, so the RAM aliases.
    assign io_sel  = bus.mem_addr[IO_SEL_BIT];
    assign io_reg  = io_reg_e'(bus.mem_addr[3:2]);
    assign ram_idx = bus.mem_addr[IDX_W+1:2];
    assign wr_any  = |bus.mem_wmask;

    // NOTE: the RAM array has no reset branch; clearing it would need a
    // multi-cycle sweep, and its contents must survive reset anyway.
    logic [XLEN-1:0] ram [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (wr_any && !io_sel) begin
            for (int lane = 0; lane < XLEN / 8; lane++) begin
                if (bus.mem_wmask[lane]) begin
                    ram[ram_idx][lane*8 +: 8] <= bus.mem_wdata[lane*8 +: 8];
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments, so a read and a
    // write at the same edge see the pre-edge contents (read-before-write).
    always_ff @(posedge clk) begin
        if (reset) begin
            leds <= '0;
        end else if (wr_any && io_sel && io_reg == IO_LEDS) begin
            leds <= bus.mem_wdata[NUM_LEDS-1:0];
        end
    end

    always_comb begin
        rdata_d = ram[ram_idx];
        if (io_sel) begin
            case (io_reg)
                IO_LEDS:        rdata_d = XLEN'(leds);
                IO_UART_STATUS: rdata_d = status_word;
                default:        rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_rdata <= '0;
        end else if (bus.mem_rstrb) begin
            bus.mem_rdata <= rdata_d;
        end
    end

`ifdef MEM_RESPONDER_UART_EN
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int AW           = $clog2(FIFO_DEPTH);

    logic [7:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full;
    logic        push_req, push, pop;
    logic        ser_ready, ser_busy;

    // The extra pointer MSB tells a full FIFO from an empty one.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_req   = wr_any && io_sel && (io_reg == IO_UART_DATA);
    assign pop        = ser_ready && !fifo_empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push       = push_req && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= bus.mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (fifo_mem[rd_ptr[AW-1:0]]),
        .tx_valid (!fifo_empty),
        .tx_ready (ser_ready),
        .uart_tx  (uart_tx),
        .busy     (ser_busy)
    );

    always_comb begin
        status_word                  = '0;
        status_word[STATUS_BUSY_BIT] = !fifo_empty || ser_busy;
        status_word[STATUS_FULL_BIT] = fifo_full;
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.mem_addr};
`else
    assign status_word = '0;
    assign uart_tx     = 1'b1;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.mem_addr, CLK_FREQ_HZ[0], BAUD_RATE[0], FIFO_DEPTH[0]};
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int XLEN       = 32;
    localparam int MEM_WORDS  = 2048;
    localparam int NUM_LEDS   = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int CPB        = 4;

    localparam logic [31:0] A_LEDS   = 32'h0040_0000;
    localparam logic [31:0] A_UDATA  = 32'h0040_0004;
    localparam logic [31:0] A_STATUS = 32'h0040_0008;
    localparam logic [31:0] A_RESV   = 32'h0040_000C;

    logic                clk = 1'b0;
    logic                reset;
    logic [NUM_LEDS-1:0] leds;
    logic                uart_tx;

    mem_responder_if #(.XLEN(XLEN)) bus ();

    mem_responder #(
        .XLEN(XLEN), .MEM_WORDS(MEM_WORDS), .NUM_LEDS(NUM_LEDS),
        .CLK_FREQ_HZ(400), .BAUD_RATE(100), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .leds(leds), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd_hold;

    typedef struct {
        logic        rd;
        logic [3:0]  wm;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [4:0]  exp_leds;
        string       name;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive at negedge, expected read value queued, compared
    // after the edge. Unstrobed cycles must leave mem_rdata unchanged.
    task automatic step(input logic rd, input logic [3:0] wm, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp, input string name);
        logic [31:0] e;
        @(negedge clk);
        bus.mem_rstrb = rd;
        bus.mem_wmask = wm;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        if (rd) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (rd) begin
            e = exp_q.pop_front();
            check(name, bus.mem_rdata, e);
            rd_hold = e;
        end else begin
            check({name, "_hold"}, bus.mem_rdata, rd_hold);
        end
        bus.mem_rstrb = 1'b0;
        bus.mem_wmask = 4'h0;
    endtask

`ifdef MEM_RESPONDER_UART_EN
    // Expected line level for cycle c of a run of back-to-back frames.
    function automatic logic frame_bit(input int c, input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3,
                                       input logic [7:0] b4, input int nframes);
        logic [7:0] bytes [5];
        int f, b;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3; bytes[4] = b4;
        f = c / (10 * CPB);
        b = (c % (10 * CPB)) / CPB;
        if (f >= nframes) return 1'b1;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return bytes[f][b-1];
    endfunction
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 4'hF, 32'h100,    32'hDEADBEEF, 32'h0,        5'h00, "w_full"};
        vecs[1]  = '{1'b1, 4'h0, 32'h100,    32'h0,        32'hDEADBEEF, 5'h00, "r_full"};
        vecs[2]  = '{1'b0, 4'h1, 32'h100,    32'h000000AA, 32'h0,        5'h00, "w_lane0"};
        vecs[3]  = '{1'b0, 4'h4, 32'h100,    32'h55555555, 32'h0,        5'h00, "w_lane2"};
        vecs[4]  = '{1'b1, 4'h0, 32'h100,    32'h0,        32'hDE55BEAA, 5'h00, "r_merge"};
        vecs[5]  = '{1'b1, 4'h0, 32'h100 + 4*MEM_WORDS, 32'h0, 32'hDE55BEAA, 5'h00, "r_alias"};
        vecs[6]  = '{1'b0, 4'hF, 32'h200,    32'h11111111, 32'h0,        5'h00, "w_200"};
        vecs[7]  = '{1'b1, 4'hF, 32'h200,    32'h22222222, 32'h11111111, 5'h00, "rw_old"};
        vecs[8]  = '{1'b1, 4'h0, 32'h200,    32'h0,        32'h22222222, 5'h00, "r_new"};
        vecs[9]  = '{1'b0, 4'hF, A_LEDS,     32'h0000001F, 32'h0,        5'h1F, "w_leds"};
        vecs[10] = '{1'b1, 4'h0, A_LEDS,     32'h0,        32'h0000001F, 5'h1F, "r_leds"};
        vecs[11] = '{1'b0, 4'h0, A_LEDS,     32'h0,        32'h0,        5'h1F, "w_mask0"};
        vecs[12] = '{1'b0, 4'hF, A_LEDS,     32'hFFFFFFE3, 32'h0,        5'h03, "w_leds2"};
        vecs[13] = '{1'b1, 4'h0, A_RESV,     32'h0,        32'h0,        5'h03, "r_resv"};
        vecs[14] = '{1'b1, 4'h0, A_UDATA,    32'h0,        32'h0,        5'h03, "r_udata"};
        vecs[15] = '{1'b0, 4'hF, A_RESV,     32'hFFFFFFFF, 32'h0,        5'h03, "w_resv"};
        vecs[16] = '{1'b1, 4'h0, A_LEDS,     32'h0,        32'h00000003, 5'h03, "r_leds2"};

        bus.mem_addr  = '0;
        bus.mem_rstrb = 1'b0;
        bus.mem_wmask = 4'h0;
        bus.mem_wdata = '0;
        reset         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", bus.mem_rdata, 32'h0);
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_tx", 32'(uart_tx), 32'h1);
        rd_hold = 32'h0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rd, vecs[i].wm, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].name);
            check({vecs[i].name, "_leds"}, 32'(leds), 32'(vecs[i].exp_leds));
        end

        // Reset clears LEDS and rdata but not RAM.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_leds", 32'(leds), 32'h0);
        check("rst2_rdata", bus.mem_rdata, 32'h0);
        rd_hold = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 4'h0, 32'h100, 32'h0, 32'hDE55BEAA, "r_after_rst");

`ifdef MEM_RESPONDER_UART_EN
        // Single frame of 0x41, status busy throughout.
        check("t4_idle_tx", 32'(uart_tx), 32'h1);
        step(1'b0, 4'hF, A_UDATA, 32'h00000041, 32'h0, "t4_push");
        for (int c = 0; c < 10 * CPB; c++) begin
            step(1'b1, 4'h0, A_STATUS, 32'h0, 32'h1, "t4_status");
            check("t4_tx", 32'(uart_tx), 32'(frame_bit(c, 8'h41, 8'h0, 8'h0, 8'h0, 8'h0, 1)));
        end
        step(1'b1, 4'h0, A_STATUS, 32'h0, 32'h1, "t4_status_stop_end");
        check("t4_tx_end", 32'(uart_tx), 32'h1);
        step(1'b1, 4'h0, A_STATUS, 32'h0, 32'h0, "t4_status_idle");

        // FIFO overflow: one frame in flight, six pushes, last two dropped.
        step(1'b0, 4'hF, A_UDATA, 32'h00000010, 32'h0, "t5_push0");
        for (int c = 0; c < 215; c++) begin
            if (c == 0)
                step(1'b1, 4'h0, A_STATUS, 32'h0, 32'h1, "t5_status_busy");
            else if (c <= 6)
                step(1'b0, 4'hF, A_UDATA, 32'h20 + 32'(c), 32'h0, "t5_push");
            else if (c == 7)
                step(1'b1, 4'h0, A_STATUS, 32'h0, 32'h3, "t5_status_full");
            else if (c == 44)
                step(1'b1, 4'h0, A_STATUS, 32'h0, 32'h1, "t5_status_drain");
            else if (c == 201)
                step(1'b1, 4'h0, A_STATUS, 32'h0, 32'h0, "t5_status_done");
            else
                step(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, "t5_idle");
            check("t5_tx", 32'(uart_tx),
                  32'(frame_bit(c, 8'h10, 8'h21, 8'h22, 8'h23, 8'h24, 1 + FIFO_DEPTH)));
        end

        // Reset during data bit 3 of a zero byte, with a second byte queued.
        step(1'b0, 4'hF, A_UDATA, 32'h00000000, 32'h0, "t6_push0");
        step(1'b0, 4'hF, A_UDATA, 32'h00000000, 32'h0, "t6_push1");
        check("t6_tx_start", 32'(uart_tx), 32'h0);
        for (int c = 1; c < 4 * CPB + 1; c++) begin
            step(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, "t6_idle");
            check("t6_tx_low", 32'(uart_tx), 32'h0);
        end
        reset   = 1'b1;
        rd_hold = 32'h0;
        step(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, "t6_reset");
        check("t6_tx_after_rst", 32'(uart_tx), 32'h1);
        reset = 1'b0;
        step(1'b1, 4'h0, A_STATUS, 32'h0, 32'h0, "t6_status");
        for (int c = 0; c < 60; c++) begin
            step(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, "t6_quiet");
            check("t6_tx_quiet", 32'(uart_tx), 32'h1);
        end
`else
        // UART absent: data writes vanish, status reads 0, line stays high.
        step(1'b0, 4'hF, A_UDATA, 32'h00000041, 32'h0, "nu_push");
        step(1'b1, 4'h0, A_STATUS, 32'h0, 32'h0, "nu_status");
        for (int c = 0; c < 50; c++) begin
            step(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, "nu_idle");
            check("nu_tx", 32'(uart_tx), 32'h1);
        end
`endif

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
